// File: rtl/vga_sync_pkg.sv
// Shared VGA timing constants for the sync generator and the downstream text/ROM generator.
// Defaults describe 640x480 at 60 Hz with a 25 MHz pixel clock.
package vga_sync_pkg;

   localparam int unsigned VGA_H_DISPLAY = 640;
   localparam int unsigned VGA_H_FRONT   = 16;
   localparam int unsigned VGA_H_SYNC    = 96;
   localparam int unsigned VGA_H_BACK    = 48;
   localparam int unsigned VGA_V_DISPLAY = 480;
   localparam int unsigned VGA_V_FRONT   = 10;
   localparam int unsigned VGA_V_SYNC    = 2;
   localparam int unsigned VGA_V_BACK    = 33;

   localparam int unsigned VGA_H_TOTAL =
      VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
   localparam int unsigned VGA_V_TOTAL =
      VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

   typedef logic [9:0] count_t;

   // Inclusive window test shared by the hsync and vsync decoders.
   function automatic logic in_span(input count_t c, input count_t lo, input count_t hi);
      return (c >= lo) && (c <= hi);
   endfunction

endpackage

// File: rtl/vga_sync_if.sv
// Timing bundle from the sync generator to display consumers.
interface vga_sync_if;
   import vga_sync_pkg::*;

   logic   hsync;
   logic   vsync;
   logic   video_on;
   logic   p_tick;
   logic   frame_end;
   count_t pixel_x;
   count_t pixel_y;

   modport master (
      output hsync, vsync, video_on, p_tick, frame_end, pixel_x, pixel_y
   );

   modport slave (
      input hsync, vsync, video_on, p_tick, frame_end, pixel_x, pixel_y
   );

endinterface

// File: rtl/tick_gen.sv
// Pixel-rate strobe: one-clk registered pulse every TICK_DIV clocks.
module tick_gen #(
   parameter int unsigned TICK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            tick_q;

   always_comb begin
      cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
   end

   // Registered strobe: first pulse lands TICK_DIV edges after reset release.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= (cnt_q == CntLast);
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/vga_sync.sv
// VGA horizontal/vertical sync generator; sync and blanking are registered from the
// next-state counts so they switch on the same edge as pixel_x/pixel_y.
module vga_sync
   import vga_sync_pkg::*;
#(
   parameter int unsigned TICK_DIV  = 4,
   parameter int unsigned H_DISPLAY = VGA_H_DISPLAY,
   parameter int unsigned H_FRONT   = VGA_H_FRONT,
   parameter int unsigned H_SYNC    = VGA_H_SYNC,
   parameter int unsigned H_BACK    = VGA_H_BACK,
   parameter int unsigned V_DISPLAY = VGA_V_DISPLAY,
   parameter int unsigned V_FRONT   = VGA_V_FRONT,
   parameter int unsigned V_SYNC    = VGA_V_SYNC,
   parameter int unsigned V_BACK    = VGA_V_BACK
) (
   input logic        clk,
   input logic        reset,
   vga_sync_if.master vga
);

   localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam count_t HLast      = count_t'(H_TOTAL - 1);
   localparam count_t VLast      = count_t'(V_TOTAL - 1);
   localparam count_t HVisible   = count_t'(H_DISPLAY);
   localparam count_t VVisible   = count_t'(V_DISPLAY);
   localparam count_t HSyncStart = count_t'(H_DISPLAY + H_FRONT);
   localparam count_t HSyncEnd   = count_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam count_t VSyncStart = count_t'(V_DISPLAY + V_FRONT);
   localparam count_t VSyncEnd   = count_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

   logic   p_tick;
   count_t h_q, h_d;
   count_t v_q, v_d;
   logic   hsync_q, vsync_q, video_on_q;

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk   (clk),
      .reset (reset),
      .tick  (p_tick)
   );

   always_comb begin
      h_d = h_q;
      v_d = v_q;
      if (p_tick) begin
         if (h_q == HLast) begin
            h_d = '0;
            v_d = (v_q == VLast) ? '0 : v_q + 1'b1;
         end else begin
            h_d = h_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         h_q        <= '0;
         v_q        <= '0;
         hsync_q    <= 1'b1;
         vsync_q    <= 1'b1;
         video_on_q <= 1'b0;
      end else begin
         h_q        <= h_d;
         v_q        <= v_d;
         hsync_q    <= !in_span(h_d, HSyncStart, HSyncEnd);
         vsync_q    <= !in_span(v_d, VSyncStart, VSyncEnd);
         video_on_q <= (h_d < HVisible) && (v_d < VVisible);
      end
   end

   assign vga.pixel_x   = h_q;
   assign vga.pixel_y   = v_q;
   assign vga.hsync     = hsync_q;
   assign vga.vsync     = vsync_q;
   assign vga.video_on  = video_on_q;
   assign vga.p_tick    = p_tick;
   // The strobe that wraps both counters on this cycle marks the frame's last pixel.
   assign vga.frame_end = p_tick && (h_q == HLast) && (v_q == VLast);

endmodule

// File: tb/tb_vga_sync.sv
// Scoreboard bench: a default 640x480 instance and a tiny TICK_DIV=2 instance checked
// cycle by cycle against a closed-form timing model, plus directed alignment checks.
module tb_vga_sync;
   import vga_sync_pkg::*;

   typedef struct packed {
      logic   hsync;
      logic   vsync;
      logic   video_on;
      logic   p_tick;
      logic   frame_end;
      count_t x;
      count_t y;
   } obs_t;

   logic clk = 1'b0;
   logic rst_a, rst_b;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   vga_sync_if bus_a ();
   vga_sync_if bus_b ();

   vga_sync u_dut_a (
      .clk   (clk),
      .reset (rst_a),
      .vga   (bus_a)
   );

   vga_sync #(
      .TICK_DIV  (2),
      .H_DISPLAY (16),
      .H_FRONT   (4),
      .H_SYNC    (6),
      .H_BACK    (4),
      .V_DISPLAY (10),
      .V_FRONT   (2),
      .V_SYNC    (2),
      .V_BACK    (3)
   ) u_dut_b (
      .clk   (clk),
      .reset (rst_b),
      .vga   (bus_b)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Expected outputs k edges after reset release (k = 0: still in reset).
   function automatic obs_t model(input int unsigned k, input int unsigned d,
                                  input int unsigned hd, input int unsigned hf,
                                  input int unsigned hs, input int unsigned hb,
                                  input int unsigned vd, input int unsigned vf,
                                  input int unsigned vs, input int unsigned vb);
      obs_t        o;
      int unsigned ht, vt, n, h, v;
      o = '0;
      if (k == 0) begin
         o.hsync = 1'b1;
         o.vsync = 1'b1;
         return o;
      end
      ht = hd + hf + hs + hb;
      vt = vd + vf + vs + vb;
      n  = (k - 1) / d;
      h  = n % ht;
      v  = (n / ht) % vt;
      o.p_tick    = (k >= d) && (k % d == 0);
      o.x         = count_t'(h);
      o.y         = count_t'(v);
      o.hsync     = !((h >= hd + hf) && (h < hd + hf + hs));
      o.vsync     = !((v >= vd + vf) && (v < vd + vf + vs));
      o.video_on  = (h < hd) && (v < vd);
      o.frame_end = o.p_tick && (h == ht - 1) && (v == vt - 1);
      return o;
   endfunction

   function automatic obs_t sample_a();
      return '{bus_a.hsync, bus_a.vsync, bus_a.video_on, bus_a.p_tick, bus_a.frame_end,
               bus_a.pixel_x, bus_a.pixel_y};
   endfunction

   function automatic obs_t sample_b();
      return '{bus_b.hsync, bus_b.vsync, bus_b.video_on, bus_b.p_tick, bus_b.frame_end,
               bus_b.pixel_x, bus_b.pixel_y};
   endfunction

   obs_t        q_a[$];
   obs_t        q_b[$];
   int unsigned k_a = 0;
   int unsigned k_b = 0;

   // Push the expected post-edge state for each DUT on every rising edge.
   initial begin
      forever begin
         @(posedge clk);
         k_a = rst_a ? 0 : k_a + 1;
         k_b = rst_b ? 0 : k_b + 1;
         q_a.push_back(model(k_a, 4, 640, 16, 96, 48, 480, 10, 2, 33));
         q_b.push_back(model(k_b, 2, 16, 4, 6, 4, 10, 2, 2, 3));
      end
   end

   initial begin
      obs_t e;
      forever begin
         @(negedge clk);
         if (q_a.size() > 0) begin
            e = q_a.pop_front();
            check_val("a_cycle", 32'(sample_a()), 32'(e));
         end
         if (q_b.size() > 0) begin
            e = q_b.pop_front();
            check_val("b_cycle", 32'(sample_b()), 32'(e));
         end
      end
   end

   // Directed monitors.
   logic        a_first_run = 1'b1;
   int          hs_low_cnt  = 0;
   int          hs_first_x  = -1;
   int          tick_bad    = 0;
   int          tick_meas   = 0;
   int          fe_len_chk  = 0;
   logic [31:0] vs_mask     = '0;

   initial begin
      int     cyc      = 0;
      int     last_tk  = -1;
      int     last_fe  = -1;
      logic   want_zero = 1'b0;
      count_t prev_x   = '0;
      logic   prev_hs  = 1'b1;
      logic   prev_vo  = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst_a) begin
            last_tk = -1;
         end else begin
            if (bus_a.p_tick) begin
               if (last_tk >= 0) begin
                  tick_meas++;
                  if (cyc - last_tk != 4) tick_bad++;
               end
               last_tk = cyc;
            end
            if (a_first_run && bus_a.pixel_y == 0 && bus_a.p_tick && !bus_a.hsync) begin
               hs_low_cnt++;
               if (hs_first_x < 0) hs_first_x = int'(bus_a.pixel_x);
            end
            if (prev_x == 10'd655 && bus_a.pixel_x == 10'd656)
               check_val("a_hs_fall_656", {30'd0, prev_hs, bus_a.hsync}, 32'b10);
            if (prev_x == 10'd639 && bus_a.pixel_x == 10'd640 && bus_a.pixel_y == 0)
               check_val("a_vo_fall_640", {30'd0, prev_vo, bus_a.video_on}, 32'b10);
         end
         prev_x  = bus_a.pixel_x;
         prev_hs = bus_a.hsync;
         prev_vo = bus_a.video_on;

         if (rst_b) begin
            last_fe   = -1;
            want_zero = 1'b0;
         end else begin
            if (!bus_b.vsync && bus_b.pixel_y < 32) vs_mask[bus_b.pixel_y[4:0]] = 1'b1;
            if (want_zero && bus_b.p_tick && !bus_b.frame_end) begin
               check_val("b_wrap_xy", {12'd0, bus_b.pixel_x, bus_b.pixel_y}, 32'd0);
               want_zero = 1'b0;
            end
            if (bus_b.frame_end) begin
               check_val("b_fe_xy", {12'd0, bus_b.pixel_x, bus_b.pixel_y},
                         {12'd0, 10'd29, 10'd16});
               if (last_fe >= 0) begin
                  fe_len_chk++;
                  check_val("b_frame_len", 32'(cyc - last_fe), 32'd1020);
               end
               last_fe   = cyc;
               want_zero = 1'b1;
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      step(5);
      rst_a = 1'b0;
      rst_b = 1'b0;
      step(1);
      @(negedge clk);
      check_val("a_vo_after_release", 32'(bus_a.video_on), 32'd1);
      check_val("a_no_tick_edge1", 32'(bus_a.p_tick), 32'd0);
      step(3);
      @(negedge clk);
      check_val("a_first_tick_edge4", 32'(bus_a.p_tick), 32'd1);

      step(3500);
      rst_b = 1'b1;
      step(1);
      @(negedge clk);
      check_val("b_mid_reset", 32'(sample_b()), 32'({5'b11000, 10'd0, 10'd0}));
      step(2);
      rst_b = 1'b0;

      step(3101);
      a_first_run = 1'b0;
      rst_a = 1'b1;
      step(1);
      @(negedge clk);
      check_val("a_mid_reset", 32'(sample_a()), 32'({5'b11000, 10'd0, 10'd0}));
      step(2);
      rst_a = 1'b0;
      step(4000);

      check_val("a_hs_low_pixels", 32'(hs_low_cnt), 32'd96);
      check_val("a_hs_first_x", 32'(hs_first_x), 32'd656);
      check_val("a_tick_period_bad", 32'(tick_bad), 32'd0);
      check_val("a_tick_seen", 32'(tick_meas > 1000), 32'd1);
      check_val("b_vsync_lines", vs_mask, 32'h0000_3000);
      check_val("b_frame_len_seen", 32'(fe_len_chk >= 2), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
